// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select, auto-scan with programmable
// dwell, hold/freeze control, and valid/wrap status flags.
module mux_scan_n #(
  parameter int unsigned N     = 3,
  parameter int unsigned W     = 4,
  parameter int unsigned DWELL = 4,
  localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] x,
  input  logic [AW-1:0]  adr,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   y,
  output logic [AW-1:0]  ch,
  output logic           y_vld,
  output logic           wrap
);

  localparam int unsigned    CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [AW-1:0] IdxLast  = AW'(N - 1);
  localparam logic [CW-1:0] CntLast  = CW'(DWELL - 1);
  localparam logic [AW:0]   NumCh    = (AW + 1)'(N);

  typedef enum logic [1:0] {StMan, StScan, StHold} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resume_q, resume_d;
  logic [W-1:0]  y_q, y_d;
  logic [AW-1:0] ch_q, ch_d;
  logic          vld_q, vld_d;
  logic          wrap_q, wrap_d;

  logic          last_cnt;
  logic          cont_scan;
  logic          adr_ok;
  logic [AW-1:0] idx_step;
  logic [AW-1:0] sel;
  logic [N-1:0]  onehot;
  logic [W-1:0]  mux_out;

  // Scan continues only from SCAN, or from HOLD when the hold began in a live scan and
  // mode stayed high throughout.
  always_comb begin
    last_cnt  = (cnt_q == CntLast);
    cont_scan = (state_q == StScan) || ((state_q == StHold) && resume_q);
    adr_ok    = ({1'b0, adr} < NumCh);
    idx_step  = idx_q;
    if (last_cnt) begin
      idx_step = (idx_q == IdxLast) ? '0 : idx_q + AW'(1);
    end
    sel = '0;
    if (!mode) begin
      sel = adr;
    end else if (cont_scan) begin
      sel = idx_step;
    end
  end

  // One-hot decode then AND-OR; an out-of-range select matches no channel and yields 0.
  always_comb begin
    onehot  = '0;
    mux_out = '0;
    for (int unsigned k = 0; k < N; k++) begin
      onehot[k] = (sel == AW'(k));
      mux_out   = mux_out | (x[k*W +: W] & {W{onehot[k]}});
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;
    y_d      = y_q;
    ch_d     = ch_q;
    vld_d    = 1'b0;
    wrap_d   = 1'b0;
    if (hold) begin
      state_d = StHold;
      if (state_q != StHold) begin
        resume_d = (state_q == StScan) && mode;
      end else if (!mode) begin
        resume_d = 1'b0;
      end
    end else if (!mode) begin
      state_d = StMan;
      y_d     = mux_out;
      ch_d    = adr;
      vld_d   = adr_ok;
    end else if (cont_scan) begin
      state_d = StScan;
      idx_d   = idx_step;
      cnt_d   = last_cnt ? '0 : cnt_q + CW'(1);
      wrap_d  = last_cnt && (idx_q == IdxLast);
      y_d     = mux_out;
      ch_d    = idx_step;
      vld_d   = 1'b1;
    end else begin
      state_d = StScan;
      idx_d   = '0;
      cnt_d   = '0;
      y_d     = mux_out;
      ch_d    = '0;
      vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StMan;
      idx_q    <= '0;
      cnt_q    <= '0;
      resume_q <= 1'b0;
      y_q      <= '0;
      ch_q     <= '0;
      vld_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
      y_q      <= y_d;
      ch_q     <= ch_d;
      vld_q    <= vld_d;
      wrap_q   <= wrap_d;
    end
  end

  assign y     = y_q;
  assign ch    = ch_q;
  assign y_vld = vld_q;
  assign wrap  = wrap_q;

endmodule
